// File: rtl/mem_responder.sv
// Wait-state memory responder for the multicycle core's unified memory port.
// Optional address checking is enabled with `define MEM_RESPONDER_ERR_EN.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemW,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemAck,
  output logic        MemErr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        cap_w;
  logic [31:0] cap_adr, cap_wd;
  logic        commit;
  logic        c_w, c_err;
  logic [31:0] c_adr, c_wd;
  logic [AW-1:0] idx;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  // With no wait states the commit happens on the acceptance edge, so the
  // live request inputs are used instead of the (not yet loaded) captures.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    c_w       = cap_w;
    c_adr     = cap_adr;
    c_wd      = cap_wd;
    case (state)
      S_IDLE: begin
        c_w   = MemW;
        c_adr = Adr;
        c_wd  = WriteData;
        if (MemReq) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = S_RESP;
          commit    = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign idx = c_adr[AW+1:2];

`ifdef MEM_RESPONDER_ERR_EN
  assign c_err = (c_adr[1:0] != 2'b00) || (c_adr >= 32'(4 * DEPTH_WORDS));
`else
  logic unused_adr_bits;
  assign unused_adr_bits = ^{c_adr[31:AW+2], c_adr[1:0]};
  assign c_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cap_w    <= 1'b0;
      cap_adr  <= '0;
      cap_wd   <= '0;
      ReadData <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && MemReq) begin
        cap_w   <= MemW;
        cap_adr <= Adr;
        cap_wd  <= WriteData;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_q <= c_err;
        if (!c_w)
          ReadData <= c_err ? '0 : mem[idx];
      end
    end
  end

  // Storage is not reset; writes are gated so nothing commits while in reset.
  always_ff @(posedge clk) begin
    if (reset && commit && c_w && !c_err)
      mem[idx] <= c_wd;
  end

  assign MemAck = (state == S_RESP);
  assign MemErr = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance 0 with two wait states,
// instance 1 with none, both 64 words deep.
module tb_mem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        req [2];
  logic        w   [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [31:0] rd  [2];
  logic        ack [2];
  logic        err [2];

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] mm [2][DEPTH];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .reset(rst[0]), .MemReq(req[0]), .MemW(w[0]), .Adr(adr[0]),
    .WriteData(wd[0]), .ReadData(rd[0]), .MemAck(ack[0]), .MemErr(err[0]));

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(rst[1]), .MemReq(req[1]), .MemW(w[1]), .Adr(adr[1]),
    .WriteData(wd[1]), .ReadData(rd[1]), .MemAck(ack[1]), .MemErr(err[1]));

  function automatic int unsigned wait_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %h expected %h (cycle %0d)", nm, i, act, exp, cyc);
    end
  endtask

  // Reference behaviour: one completed access from the requester's viewpoint.
  function automatic exp_t model(input int i, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d);
    exp_t e;
    int unsigned ix;
    logic bad;
`ifdef MEM_RESPONDER_ERR_EN
    bad = (a % 4 != 0) || (a >= 4 * DEPTH);
`else
    bad = 1'b0;
`endif
    ix = (a / 4) % DEPTH;
    if (wr) begin
      if (!bad) mm[i][ix] = d;
    end else begin
      last_rd[i] = bad ? 32'h0 : mm[i][ix];
    end
    e.data = last_rd[i];
    e.err  = bad;
    e.cyc  = 0;
    return e;
  endfunction

  task automatic push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_ack(input int i, input string nm);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ack[i] && t < 40);
    if (!ack[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout inst%0d: got no ack expected ack within 40 cycles", nm, i);
    end
  endtask

  task automatic access(input int i, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
    exp_t e;
    int unsigned acc;
    @(negedge clk);
    req[i] = 1'b1;
    w[i]   = wr;
    adr[i] = a;
    wd[i]  = d;
    acc    = cyc + 1;
    e      = model(i, wr, a, d);
    e.cyc  = acc + wait_of(i);
    push(i, e);
    if (hold) begin
      e     = model(i, wr, a, d);
      e.cyc = acc + 2 * wait_of(i) + 2;
      push(i, e);
    end
    wait_ack(i, "ack");
    if (hold) wait_ack(i, "held_ack");
    req[i] = 1'b0;
    w[i]   = $urandom_range(0, 1);
    adr[i] = $urandom;
    wd[i]  = $urandom;
  endtask

  task automatic mon(input int i);
    exp_t e;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_ack inst%0d: got ack expected none (cycle %0d)", i, cyc);
      return;
    end
    e = (i == 0) ? q0.pop_front() : q1.pop_front();
    chk("ack_cycle", i, cyc, e.cyc);
    chk("read_data", i, rd[i], e.data);
    chk("mem_err", i, {31'b0, err[i]}, {31'b0, e.err});
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (rst[i] && ack[i]) mon(i);
  end

  task automatic chk_reset_outputs(input int i);
    chk("rst_ack", i, {31'b0, ack[i]}, 32'h0);
    chk("rst_err", i, {31'b0, err[i]}, 32'h0);
    chk("rst_rdata", i, rd[i], 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; w[i] = 1'b0; adr[i] = '0; wd[i] = '0;
      last_rd[i] = '0;
    end
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) chk_reset_outputs(i);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    repeat (6) @(negedge clk);

    // Give every word a known value before any load.
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < DEPTH; k++)
        access(i, 1'b1, 32'(4 * k), $urandom, 1'b0);

    for (int i = 0; i < 2; i++) begin
      access(i, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      access(i, 1'b0, 32'h10, 32'h0, 1'b0);
    end
    access(1, 1'b1, 32'h3C, 32'h12345678, 1'b0);
    access(1, 1'b0, 32'h3C, 32'h0, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b1);
    access(1, 1'b0, 32'h3C, 32'h0, 1'b1);

    // Reset in the middle of a store's wait states discards the store.
    access(0, 1'b1, 32'h20, 32'h11111111, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; w[0] = 1'b1; adr[0] = 32'h20; wd[0] = 32'hCAFEF00D;
    @(negedge clk);
    req[0] = 1'b0;
    rst[0] = 1'b0;
    @(negedge clk);
    chk_reset_outputs(0);
    rst[0] = 1'b1;
    last_rd[0] = '0;
    access(0, 1'b0, 32'h20, 32'h0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      access(i, 1'b0, 32'h102, 32'h0, 1'b0);
      access(i, 1'b1, 32'h100, 32'hA5A5A5A5, 1'b0);
      access(i, 1'b0, 32'h0, 32'h0, 1'b0);
      access(i, 1'b1, 32'h44, 32'h0BADF00D, 1'b0);
      access(i, 1'b0, 32'h0, 32'h0, 1'b0);
    end

    for (int n = 0; n < 120; n++) begin
      int i;
      logic [31:0] a;
      i = n % 2;
      case ($urandom_range(0, 3))
        0, 1:    a = 32'(4 * $urandom_range(0, DEPTH - 1));
        2:       a = 32'($urandom_range(0, 4 * DEPTH - 1));
        default: a = $urandom;
      endcase
      access(i, 1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 9) == 0));
    end

    repeat (8) @(negedge clk);
    chk("q0_drained", 0, 32'(q0.size()), 32'h0);
    chk("q1_drained", 1, 32'(q1.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end expected finish before 2ms");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory responder for the multicycle ARM core's unified instruction/data port. It is the slave end of the core's memory interface: it accepts a fetch, load or store request and services it after a configurable number of wait states. It returns read data with a one-cycle acknowledge, and replaces the zero-latency behavioural memory in the multicycle testbench and top level.

## Interface
Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; power of two, 4..4096
- WAIT_CYCLES, 2, wait states inserted before the acknowledge; 0..15

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  active-low, asynchronous assert, synchronous release by the system
- MemReq  input  1  request strobe, sampled only in IDLE
- MemW  input  1  1 = store, 0 = load/fetch; captured with MemReq
- Adr  input  32  byte address; captured with MemReq
- WriteData  input  32  store data; captured with MemReq
- ReadData  output  32  registered load data
- MemAck  output  1  one-cycle completion pulse
- MemErr  output  1  error flag, valid only when MemAck=1

## Operation
- Storage is an array of DEPTH_WORDS x 32 indexed by Adr[log2(DEPTH_WORDS)+1:2]. Contents are not reset.
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - If MemReq=1, register Adr, MemW and WriteData, and load the wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - If MemReq=0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter equals 1, the next state is RESP.
  - Input changes are ignored because the request is already latched.
- Transition into RESP (commit edge):
  - Store: write the captured WriteData to the captured word.
  - Load: register the word into ReadData.
- RESP:
  - Assert MemAck=1 for exactly one cycle. Next state is IDLE.
  - MemReq is ignored in RESP. If MemReq is still high in the following IDLE cycle, it is treated as a new request. The requester deasserts MemReq in the MemAck cycle to avoid a duplicate access.
- ReadData holds its value until the next load commit. A store leaves ReadData unchanged.
- Reset (reset=0) at any time:
  - State goes to IDLE; MemAck=0, MemErr=0, ReadData=0; counter cleared.
  - A store whose commit edge has not yet occurred is discarded.
- Reset values of all outputs are 0.

## Timing
- Request accepted at edge N → MemAck high during cycle N+WAIT_CYCLES+1 → back in IDLE at edge N+WAIT_CYCLES+2.
- Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- With WAIT_CYCLES=0, MemAck is high in the cycle after acceptance.
- Load data and MemErr are valid in the same cycle as MemAck.
- Store data is visible to a load accepted on any later edge.
- A store followed immediately by a load to the same word returns the new data.

## Configuration
Macro: MEM_RESPONDER_ERR_EN.
- Defined:
  - A request is in error if Adr[1:0]≠0 or Adr ≥ 4*DEPTH_WORDS. The check is done on the captured address.
  - An errored store performs no write.
  - An errored load sets ReadData=0.
  - MemErr=1 together with MemAck. Handshake timing is unchanged.
- Not defined:
  - Adr[1:0] is ignored and the index wraps modulo DEPTH_WORDS.
  - MemErr is tied to 0 and no error logic is synthesized.

## Test plan
- Reset with WAIT_CYCLES=2: hold reset=0 for 3 cycles → MemAck=0, MemErr=0, ReadData=0x00000000; after release, state is IDLE and no ack appears without a request.
- Store then load: store 0xDEADBEEF to Adr=0x10 (accepted at edge N) → MemAck only in cycle N+3. Then load from 0x10 → ReadData=0xDEADBEEF with MemAck, MemErr=0.
- Held request: keep MemReq=1 through the ack cycle → a second access starts in the next IDLE cycle and a second MemAck arrives 4 cycles after the first (WAIT_CYCLES=2).
- WAIT_CYCLES=0 back-to-back: store 0x12345678 to 0x3C, then load from 0x3C on the next IDLE edge → each MemAck is one cycle after acceptance; the load returns 0x12345678.
- Reset mid-operation: pull reset=0 during WAIT of a store of 0xCAFEF00D to 0x20, where 0x20 was previously 0x11111111 → after release, a load from 0x20 returns 0x11111111.
- With MEM_RESPONDER_ERR_EN, DEPTH_WORDS=64:
  - Load from 0x102 → MemAck=1, MemErr=1, ReadData=0.
  - Store to 0x100 → MemErr=1, and word 0 is unchanged.
  - Without the macro, a store to 0x100 → word 0 is written and MemErr=0.
